// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with elaboration-time frame format
module uart_tx_fifo #(
    parameter int clock_freq  = 10000000,
    parameter int baud_rate   = 9600,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1,
    parameter int fifo_depth  = 4
) (
    input  logic                          uart_clock,
    input  logic                          uart_reset,
    input  logic                          uart_start,
    input  logic [data_bits-1:0]          uart_d_in,
    output logic                          uart_d_out,
    output logic                          uart_tx_ready,
    output logic                          uart_tx_busy,
    output logic [$clog2(fifo_depth):0]   uart_fifo_count,
    output logic                          uart_overflow
);
    localparam int cpb = clock_freq / baud_rate;
    localparam int tw  = $clog2(cpb);
    localparam int aw  = $clog2(fifo_depth);

    if (cpb < 2) begin : g_cpb_check
        $error("clks_per_bit must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic [data_bits-1:0] mem [fifo_depth];
    logic [aw-1:0]        wr_ptr, rd_ptr;
    logic [aw:0]          count;
    logic [tw-1:0]        timer;
    logic [3:0]           idx;
    logic [data_bits-1:0] shreg;
    logic                 par, tx_nxt, tick, full, push, pop;

    assign full            = count == (aw+1)'(fifo_depth);
    assign push            = uart_start && !full;
    assign tick            = timer == tw'(cpb - 1);
    assign pop             = count != 0 && (state == IDLE || (state == STOP && tick && idx == 4'(stop_bits - 1)));
    assign uart_tx_ready   = !full;
    assign uart_tx_busy    = state != IDLE || count != 0;
    assign uart_fifo_count = count;

    // state register
    always_ff @(posedge uart_clock or posedge uart_reset) begin
        if (uart_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    // next-state: bit-time and bit-index driven sequencing, STOP chains straight into START
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != 0) state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA:    if (tick && idx == 4'(data_bits - 1)) state_nxt = (parity_mode != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_nxt = STOP;
            STOP:    if (tick && idx == 4'(stop_bits - 1)) state_nxt = (count != 0) ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // line level for the current state, registered below so the pad never glitches
    always_comb begin
        tx_nxt = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : (state == PARITY) ? par : 1'b1;
    end

    // bit timer, bit index, shift register and registered line
    always_ff @(posedge uart_clock or posedge uart_reset) begin
        if (uart_reset) begin
            timer      <= '0;
            idx        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            uart_d_out <= 1'b1;
        end else begin
            timer      <= (tick || state == IDLE) ? '0 : timer + tw'(1);
            idx        <= (state_nxt != state) ? '0 : idx + 4'(tick);
            uart_d_out <= tx_nxt;
            if (pop) begin
                shreg <= mem[rd_ptr];
                par   <= (^mem[rd_ptr]) ^ (parity_mode == 2);
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // FIFO pointers, occupancy and dropped-write pulse
    always_ff @(posedge uart_clock or posedge uart_reset) begin
        if (uart_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            uart_overflow <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr + aw'(push);
            rd_ptr        <= rd_ptr + aw'(pop);
            count         <= count + (aw+1)'(push) - (aw+1)'(pop);
            uart_overflow <= uart_start && full;
        end
    end

    // FIFO storage
    always_ff @(posedge uart_clock) begin
        if (push) mem[wr_ptr] <= uart_d_in;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench over four frame formats
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    localparam int CPB [4] = '{10, 10, 10, 1041};
    localparam int NB  [4] = '{8, 8, 8, 5};
    localparam int PM  [4] = '{0, 1, 2, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};

    logic       st0 = 0, st1 = 0, st2 = 0, st3 = 0;
    logic [7:0] d0 = 0, d1 = 0, d2 = 0;
    logic [4:0] d3 = 0;
    logic       tx0, tx1, tx2, tx3, rdy0, rdy1, rdy2, rdy3;
    logic       busy0, busy1, busy2, busy3, ovf0, ovf1, ovf2, ovf3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    uart_tx_fifo #(.clock_freq(10000000), .baud_rate(1000000), .data_bits(8), .parity_mode(0), .stop_bits(1), .fifo_depth(4)) u0 (
        .uart_clock(clk), .uart_reset(rst), .uart_start(st0), .uart_d_in(d0), .uart_d_out(tx0),
        .uart_tx_ready(rdy0), .uart_tx_busy(busy0), .uart_fifo_count(cnt0), .uart_overflow(ovf0));
    uart_tx_fifo #(.clock_freq(10000000), .baud_rate(1000000), .data_bits(8), .parity_mode(1), .stop_bits(1), .fifo_depth(4)) u1 (
        .uart_clock(clk), .uart_reset(rst), .uart_start(st1), .uart_d_in(d1), .uart_d_out(tx1),
        .uart_tx_ready(rdy1), .uart_tx_busy(busy1), .uart_fifo_count(cnt1), .uart_overflow(ovf1));
    uart_tx_fifo #(.clock_freq(10000000), .baud_rate(1000000), .data_bits(8), .parity_mode(2), .stop_bits(1), .fifo_depth(4)) u2 (
        .uart_clock(clk), .uart_reset(rst), .uart_start(st2), .uart_d_in(d2), .uart_d_out(tx2),
        .uart_tx_ready(rdy2), .uart_tx_busy(busy2), .uart_fifo_count(cnt2), .uart_overflow(ovf2));
    uart_tx_fifo #(.clock_freq(10000000), .baud_rate(9600), .data_bits(5), .parity_mode(0), .stop_bits(2), .fifo_depth(4)) u3 (
        .uart_clock(clk), .uart_reset(rst), .uart_start(st3), .uart_d_in(d3), .uart_d_out(tx3),
        .uart_tx_ready(rdy3), .uart_tx_busy(busy3), .uart_fifo_count(cnt3), .uart_overflow(ovf3));

    int checks = 0;
    int errors = 0;
    int gap_last [4];
    int nfr [4];
    bit mbusy [4];
    logic [8:0] q0[$], q1[$], q2[$], q3[$];

    function automatic logic gtx(int s);
        return s == 0 ? tx0 : s == 1 ? tx1 : s == 2 ? tx2 : tx3;
    endfunction
    function automatic logic gbusy(int s);
        return s == 0 ? busy0 : s == 1 ? busy1 : s == 2 ? busy2 : busy3;
    endfunction
    function automatic logic grdy(int s);
        return s == 0 ? rdy0 : s == 1 ? rdy1 : s == 2 ? rdy2 : rdy3;
    endfunction
    function automatic logic govf(int s);
        return s == 0 ? ovf0 : s == 1 ? ovf1 : s == 2 ? ovf2 : ovf3;
    endfunction
    function automatic logic [2:0] gcnt(int s);
        return s == 0 ? cnt0 : s == 1 ? cnt1 : s == 2 ? cnt2 : cnt3;
    endfunction
    function automatic int qsize(int s);
        return s == 0 ? q0.size() : s == 1 ? q1.size() : s == 2 ? q2.size() : q3.size();
    endfunction
    function automatic void qpush(int s, logic [8:0] v);
        case (s)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction
    function automatic logic [8:0] qpop(int s);
        case (s)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setst(input int s, input logic b, input logic [8:0] v);
        case (s)
            0: begin st0 = b; d0 = v[7:0]; end
            1: begin st1 = b; d1 = v[7:0]; end
            2: begin st2 = b; d2 = v[7:0]; end
            default: begin st3 = b; d3 = v[4:0]; end
        endcase
    endtask

    // frame monitor: pops the expected word at each start bit and checks every sample of every bit
    task automatic mon(input int s);
        int gap, nbit, b;
        logic [8:0] w;
        logic [12:0] eb, obs, bad;
        logic ab, has, p, v;
        forever begin
            gap = 0;
            @(negedge clk);
            while (gtx(s) !== 1'b0) begin
                gap++;
                @(negedge clk);
            end
            mbusy[s] = 1;
            gap_last[s] = gap;
            nfr[s]++;
            nbit = 1 + NB[s] + (PM[s] != 0 ? 1 : 0) + SB[s];
            has = qsize(s) != 0;
            chk($sformatf("u%0d frame_expected", s), has, 1);
            w = has ? qpop(s) : 9'h0;
            eb = '1;
            eb[0] = 1'b0;
            p = 1'b0;
            for (int i = 0; i < NB[s]; i++) begin
                eb[1+i] = w[i];
                p ^= w[i];
            end
            if (PM[s] != 0) eb[1+NB[s]] = p ^ (PM[s] == 2);
            ab = 0;
            bad = '0;
            obs = '0;
            for (int k = 0; k < nbit * CPB[s]; k++) begin
                if (k > 0) @(negedge clk);
                if (rst) ab = 1;
                b = k / CPB[s];
                v = gtx(s);
                if (k % CPB[s] == CPB[s] / 2) obs[b] = v;
                if (v !== eb[b]) bad[b] = 1'b1;
            end
            mbusy[s] = 0;
            if (!ab)
                for (int i = 0; i < nbit; i++)
                    chk($sformatf("u%0d word%0h bit%0d {unstable,level}", s, w, i), {bad[i], obs[i]}, {1'b0, eb[i]});
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);
    initial mon(3);

    task automatic wait_done(input int s, input int budget);
        int n = 0;
        while ((mbusy[s] || qsize(s) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d drain_in_time", s), n < budget, 1);
    endtask

    task automatic wait_nfr(input int s, input int target, input int budget);
        int n = 0;
        while (nfr[s] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d frame%0d_started", s, target), n < budget, 1);
    endtask

    // single write into an idle block: latency, busy window, then drain
    task automatic single(input int s, input logic [8:0] v, input int flen);
        setst(s, 1, v);
        qpush(s, v);
        @(posedge clk);
        @(negedge clk);
        setst(s, 0, 9'h0);
        chk($sformatf("u%0d count_after_write", s), gcnt(s), 1);
        chk($sformatf("u%0d busy_after_write", s), gbusy(s), 1);
        chk($sformatf("u%0d line_idle_n0", s), gtx(s), 1);
        @(negedge clk);
        chk($sformatf("u%0d line_idle_n1", s), gtx(s), 1);
        @(negedge clk);
        chk($sformatf("u%0d line_low_n2", s), gtx(s), 0);
        repeat (flen - 2) @(negedge clk);
        chk($sformatf("u%0d busy_last_cycle", s), gbusy(s), 1);
        @(negedge clk);
        chk($sformatf("u%0d busy_fall", s), gbusy(s), 0);
        wait_done(s, flen + 50);
    endtask

    initial begin
        int base;
        #1 rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("u%0d reset_line", s), gtx(s), 1);
            chk($sformatf("u%0d reset_ready", s), grdy(s), 1);
            chk($sformatf("u%0d reset_busy", s), gbusy(s), 0);
            chk($sformatf("u%0d reset_count", s), gcnt(s), 0);
            chk($sformatf("u%0d reset_overflow", s), govf(s), 0);
        end

        single(0, 9'hA5, 100);
        single(1, 9'h5A, 110);
        single(2, 9'h5A, 110);

        base = nfr[0];
        for (int i = 0; i < 6; i++) begin
            setst(0, 1, 9'(8'h11 + i));
            if (i < 5) qpush(0, 9'(8'h11 + i));
            @(posedge clk);
            @(negedge clk);
            if (i == 4) begin
                chk("fill ready_low", rdy0, 0);
                chk("fill count_full", cnt0, 4);
                chk("fill no_overflow_yet", ovf0, 0);
            end
        end
        setst(0, 0, 9'h0);
        chk("fill overflow_pulse", ovf0, 1);
        chk("fill count_after_drop", cnt0, 4);
        @(negedge clk);
        chk("fill overflow_single", ovf0, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_nfr(0, base + k, 200);
            if (k > 1) chk($sformatf("fill gap_before_frame%0d", k), gap_last[0], 0);
            if (k == 2) begin
                chk("fill count_after_pop", cnt0, 3);
                chk("fill ready_after_pop", rdy0, 1);
            end
        end
        wait_done(0, 200);

        base = nfr[0];
        for (int i = 0; i < 3; i++) begin
            setst(0, 1, 9'(8'h31 + i));
            qpush(0, 9'(8'h31 + i));
            @(posedge clk);
            @(negedge clk);
        end
        setst(0, 0, 9'h0);
        repeat (98) @(negedge clk);
        chk("pushpop count_before", cnt0, 2);
        setst(0, 1, 9'h34);
        qpush(0, 9'h34);
        @(posedge clk);
        @(negedge clk);
        setst(0, 0, 9'h0);
        chk("pushpop count_same", cnt0, 2);
        for (int k = 2; k <= 4; k++) begin
            wait_nfr(0, base + k, 200);
            chk($sformatf("pushpop gap_before_frame%0d", k), gap_last[0], 0);
        end
        wait_done(0, 200);

        for (int i = 0; i < 3; i++) begin
            setst(0, 1, i == 0 ? 9'h00 : i == 1 ? 9'h81 : 9'h42);
            qpush(0, i == 0 ? 9'h00 : i == 1 ? 9'h81 : 9'h42);
            @(posedge clk);
            @(negedge clk);
        end
        setst(0, 0, 9'h0);
        repeat (43) @(negedge clk);
        chk("rst data_bit3_low", tx0, 0);
        chk("rst two_queued", cnt0, 2);
        #1 rst = 1;
        #1;
        chk("rst line_high_async", tx0, 1);
        chk("rst count_cleared", cnt0, 0);
        chk("rst ready_set", rdy0, 1);
        chk("rst busy_clear", busy0, 0);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        wait_done(0, 200);
        single(0, 9'h3C, 100);

        single(3, 9'h15, 8328);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
